// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/EXEC/MEM/HALT sequencer driving a 16-bit datapath
module control_unit #(
   parameter logic [5:0] RESET_PC = 6'd0
) (
   input  logic        clk_main,
   input  logic        reset,
   input  logic [15:0] instr_in,
   input  logic        Z,
   input  logic        mem_ready,
   output logic [5:0]  PC,
   output logic [3:0]  DR,
   output logic [3:0]  SA,
   output logic [3:0]  SB,
   output logic [3:0]  FS,
   output logic        MB,
   output logic        MM,
   output logic        MD,
   output logic        MW,
   output logic        RW,
   output logic [15:0] const_out,
   output logic        halted
);
   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
   state_t state, state_nx;
   logic [15:0] ir;
   logic [5:0] pc_nx;
   logic [3:0] op;
   assign op = ir[15:12];
   assign DR = ir[11:8];
   assign SA = ir[7:4];
   assign SB = ir[3:0];
   assign const_out = {12'd0, ir[3:0]};
   assign halted = (state == HALT);
   // State, PC and IR registers; IR only captures during FETCH
   always_ff @(posedge clk_main) begin
      if (reset) begin
         state <= FETCH;
         PC <= RESET_PC;
         ir <= 16'h0000;
      end else begin
         state <= state_nx;
         PC <= pc_nx;
         if (state == FETCH) ir <= instr_in;
      end
   end
   // Next-state, next-PC and datapath control decode from state and IR
   always_comb begin
      state_nx = state;
      pc_nx = PC;
      FS = 4'b0000;
      MB = 1'b0;
      MM = 1'b1;
      MD = 1'b0;
      MW = 1'b0;
      RW = 1'b0;
      case (state)
         FETCH: state_nx = EXEC;
         EXEC: begin
            state_nx = FETCH;
            pc_nx = PC + 6'd1;
            case (op)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                  FS = op;
                  RW = 1'b1;
               end
               4'h7: RW = 1'b1;
               4'h8: begin
                  FS = 4'b0001;
                  MB = 1'b1;
                  RW = 1'b1;
               end
               4'h9: begin
                  MM = 1'b0;
                  MD = 1'b1;
                  state_nx = MEM;
                  pc_nx = PC;
               end
               4'hA: begin
                  MM = 1'b0;
                  state_nx = MEM;
                  pc_nx = PC;
               end
               4'hB: pc_nx = Z ? PC + 6'd1 + {{2{ir[3]}}, ir[3:0]} : PC + 6'd1;
               4'hC: pc_nx = ir[5:0];
               4'hF: begin
                  state_nx = HALT;
                  pc_nx = PC;
               end
               default: ;
            endcase
         end
         MEM: begin
            MM = 1'b0;
            MD = (op == 4'h9);
            RW = (op == 4'h9) && mem_ready;
            MW = (op == 4'hA);
            state_nx = mem_ready ? FETCH : MEM;
            pc_nx = mem_ready ? PC + 6'd1 : PC;
         end
         HALT: ;
      endcase
   end
endmodule
